// File: rtl/stream_min_finder.sv
// Serial frame minimum finder: consumes N samples over valid/ready, reports min and first position.
// Optional STREAM_MIN_MAX_EN adds the frame maximum (out_max/out_max_idx) tracked in parallel.
module stream_min_finder #(
  parameter  int DW = 8,
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_min,
`ifdef STREAM_MIN_MAX_EN
  output logic [DW-1:0] out_max,
  output logic [IW-1:0] out_max_idx,
`endif
  output logic [IW-1:0] out_idx
);

  typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] min_q, min_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          accept;
  logic          last;

  // clear has priority over any handshake in the same cycle
  assign accept = in_valid & in_ready & ~clear;
  assign last   = (cnt_q == IW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && last) state_d = REPORT;
      REPORT:  if (clear || out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == REPORT);
    out_min   = min_q;
    out_idx   = idx_q;
  end

  // The first sample of a frame seeds the running min; strict less-than keeps the earliest tie.
  always_comb begin
    cnt_d = cnt_q;
    min_d = min_q;
    idx_d = idx_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == '0 || in_data < min_q) begin
        min_d = in_data;
        idx_d = cnt_q;
      end
      cnt_d = last ? '0 : cnt_q + IW'(1);
    end
  end

`ifdef STREAM_MIN_MAX_EN
  logic [DW-1:0] max_q, max_d;
  logic [IW-1:0] max_idx_q, max_idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q     <= '0;
      max_idx_q <= '0;
    end else begin
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
    end
  end

  always_comb begin
    max_d     = max_q;
    max_idx_d = max_idx_q;
    if (accept && (cnt_q == '0 || in_data > max_q)) begin
      max_d     = in_data;
      max_idx_d = cnt_q;
    end
  end

  assign out_max     = max_q;
  assign out_max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_stream_min_finder.sv
// Directed bench for stream_min_finder (N=4, DW=8) with an expected-result queue as scoreboard.
// Build with +define+STREAM_MIN_MAX_EN to also exercise the max path.
module tb_stream_min_finder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_min;
  logic [IW-1:0] out_idx;
`ifdef STREAM_MIN_MAX_EN
  logic [DW-1:0] out_max;
  logic [IW-1:0] out_max_idx;
`endif

  typedef struct {
    logic [DW-1:0] mn;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  stream_min_finder #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
`ifdef STREAM_MIN_MAX_EN
    .out_max     (out_max),
    .out_max_idx (out_max_idx),
`endif
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  task automatic frame(input logic [DW-1:0] a, b, c, d, input logic [DW-1:0] emn, input logic [IW-1:0] eidx);
    exp_t e;
    e.mn  = emn;
    e.idx = eidx;
    exp_q.push_back(e);
    send(a); send(b); send(c); send(d);
  endtask

  // Result is checked on the cycle after the last accept; bounded wait in case it never arrives.
  task automatic receive(input string tag);
    exp_t e;
    int   waited = 0;
    while (!out_valid && waited < 8) begin
      tick();
      waited++;
    end
    chk({tag, "_latency"}, 32'(waited), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_min"},   32'(out_min),   32'(e.mn));
    chk({tag, "_out_idx"},   32'(out_idx),   32'(e.idx));
    chk({tag, "_in_ready_lo"}, 32'(in_ready), 32'd0);
    $display("frame %s: min=0x%0h idx=%0d", tag, out_min, out_idx);
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_after_accept"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_after_accept"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_min",   32'(out_min),   32'd0);
    chk("reset_out_idx",   32'(out_idx),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back, tie at positions 1 and 3
    frame(8'd5, 8'd3, 8'd9, 8'd3, 8'd3, 2'd1);
    receive("tie");
    accept_result("tie");

    // All-maximum samples, then strictly decreasing
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0);
    receive("allff");
    accept_result("allff");
    frame(8'd7, 8'd6, 8'd5, 8'd4, 8'd4, 2'd3);
    receive("decr");
    accept_result("decr");

    // Backpressure: result held for 3 cycles while junk is offered on the input
    frame(8'd8, 8'd2, 8'd6, 8'd1, 8'd1, 2'd3);
    receive("bp");
    in_valid = 1'b1;
    in_data  = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_min",   32'(out_min),   32'd1);
      chk("bp_hold_idx",   32'(out_idx),   32'd3);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    accept_result("bp");

    // Stalled input: idle cycles carry a value that would win if miscounted
    exp_q.push_back('{mn: 8'd0, idx: 2'd2});
    send(8'd4);
    in_data = 8'd0; tick();
    send(8'd9);
    in_data = 8'd0; tick();
    send(8'd0);
    in_data = 8'd0; tick();
    send(8'd2);
    receive("stall");
    accept_result("stall");

    // clear with a concurrent sample discards the partial frame and the sample
    send(8'd1);
    send(8'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd0;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_no_report", 32'(out_valid), 32'd0);
    frame(8'd6, 8'd5, 8'd4, 8'd3, 8'd3, 2'd3);
    receive("after_clear");
    accept_result("after_clear");

    // clear in REPORT drops the result even with out_ready high
    frame(8'd20, 8'd10, 8'd30, 8'd40, 8'd10, 2'd1);
    receive("clr_rep");
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clr_rep_valid", 32'(out_valid), 32'd0);
    chk("clr_rep_ready", 32'(in_ready),  32'd1);
    $display("clear in report: out_valid=%0d in_ready=%0d", out_valid, in_ready);

`ifdef STREAM_MIN_MAX_EN
    frame(8'd5, 8'd9, 8'd1, 8'd9, 8'd1, 2'd2);
    receive("maxen");
    chk("maxen_out_max",     32'(out_max),     32'd9);
    chk("maxen_out_max_idx", 32'(out_max_idx), 32'd1);
    accept_result("maxen");
`endif

    // Asynchronous reset while a result is pending
    frame(8'd50, 8'd40, 8'd60, 8'd45, 8'd40, 2'd1);
    receive("pre_rst");
    void'(exp_q.size());
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready),  32'd1);
    chk("async_rst_min",   32'(out_min),   32'd0);
    chk("async_rst_idx",   32'(out_idx),   32'd0);
    $display("async reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    tick();
    rst = 1'b0;
    tick();

    frame(8'd12, 8'd11, 8'd13, 8'd11, 8'd11, 2'd1);
    receive("post_rst");
    accept_result("post_rst");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
